// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-bit CPU bus/control sequencer.
// Walks each instruction through opcode fetch, an optional immediate byte,
// an optional data-memory read or write, and a one-cycle execute strobe.
// HALT sleeps until an interrupt is pending. Interrupt entry pushes the PC
// high byte then the low byte, and then vectors to 0x0040 + 8*n.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   mem_*                    8-bit data / 16-bit address bus with ready handshake
//   imm_en, mem_op, is_halt  decoder results for the latched opcode
//   hl_addr, reg_wdata       address and store data for the data phase
//   pc_load, pc_target       branch-taken flag and branch target, sampled in EXEC
//   int_req, ime, sp         pending interrupts, master enable, stack pointer
//   opcode, imm, mem_data    latched instruction and operand bytes
//   pc                       program counter
//   exec_en, sp_dec, int_ack one-cycle strobes
//
// state      | meaning
// FETCH      | read opcode at pc
// DECODE     | one idle cycle while the decoder settles
// IMM        | read immediate byte at pc
// MEM        | data read/write at hl_addr
// EXEC       | execute strobe, optional branch
// HALTED     | sleep until int_req != 0
// PUSH_HI    | write pc[15:8] to sp-1
// PUSH_LO    | write pc[7:0] to sp-2
// VECTOR     | acknowledge interrupt, jump to its vector
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        imm_en,
  input  logic [1:0]  mem_op,
  input  logic        is_halt,
  input  logic [15:0] hl_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  input  logic [4:0]  int_req,
  input  logic        ime,
  input  logic [15:0] sp,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  opcode,
  output logic [7:0]  imm,
  output logic [7:0]  mem_data,
  output logic [15:0] pc,
  output logic        exec_en,
  output logic        sp_dec,
  output logic [4:0]  int_ack
);

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_IMM, ST_MEM, ST_EXEC,
    ST_HALTED, ST_PUSH_HI, ST_PUSH_LO, ST_VECTOR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  imm_q, imm_d;
  logic [7:0]  mem_data_q, mem_data_d;

  logic        data_phase;
  logic        int_pending;
  logic [2:0]  vec_n;
  logic        vec_hit;

  // Reserved mem_op 11 behaves like "none".
  assign data_phase  = (mem_op == 2'b01) || (mem_op == 2'b10);
  assign int_pending = |int_req;

  // Lowest set bit wins: scan downwards so the last match is the lowest index.
  always_comb begin
    vec_n   = 3'd0;
    vec_hit = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (int_req[i]) begin
        vec_n   = 3'(i);
        vec_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    mem_data_d = mem_data_q;
    mem_addr   = 16'h0000;
    mem_wdata  = 8'h00;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    exec_en    = 1'b0;
    sp_dec     = 1'b0;
    int_ack    = 5'b00000;

    case (state_q)
      ST_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          opcode_d = mem_rdata;
          pc_d     = pc_q + 16'd1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_halt)         state_d = ST_HALTED;
        else if (imm_en)     state_d = ST_IMM;
        else if (data_phase) state_d = ST_MEM;
        else                 state_d = ST_EXEC;
      end
      ST_IMM: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          imm_d   = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = data_phase ? ST_MEM : ST_EXEC;
        end
      end
      ST_MEM: begin
        mem_addr = hl_addr;
        if (mem_op == 2'b01) begin
          mem_wr    = 1'b1;
          mem_wdata = reg_wdata;
        end else if (mem_op == 2'b10) begin
          mem_rd = 1'b1;
          if (mem_ready) mem_data_d = mem_rdata;
        end
        if (mem_ready) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        if (pc_load) pc_d = pc_target;
        state_d = (ime && int_pending) ? ST_PUSH_HI : ST_FETCH;
      end
      ST_HALTED: begin
        if (int_pending) state_d = ime ? ST_PUSH_HI : ST_FETCH;
      end
      ST_PUSH_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = sp - 16'd1;
        mem_wdata = pc_q[15:8];
        if (mem_ready) begin
          sp_dec  = 1'b1;
          state_d = ST_PUSH_LO;
        end
      end
      ST_PUSH_LO: begin
        // sp may not reflect the first decrement yet, so address from the
        // original value.
        mem_wr    = 1'b1;
        mem_addr  = sp - 16'd2;
        mem_wdata = pc_q[7:0];
        if (mem_ready) begin
          sp_dec  = 1'b1;
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        if (vec_hit) begin
          int_ack = 5'b00001 << vec_n;
          pc_d    = 16'h0040 + {10'd0, vec_n, 3'b000};
        end
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // While reset is held, nothing leaves the block: all requests and strobes
    // stay low, so a transfer that reset interrupts is dropped.
    if (rst) begin
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      exec_en   = 1'b0;
      sp_dec    = 1'b0;
      int_ack   = 5'b00000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      imm_q      <= 8'h00;
      mem_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign pc       = pc_q;
  assign opcode   = opcode_q;
  assign imm      = imm_q;
  assign mem_data = mem_data_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        imm_en;
  logic [1:0]  mem_op;
  logic        is_halt;
  logic [15:0] hl_addr;
  logic [7:0]  reg_wdata;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [4:0]  int_req;
  logic        ime;
  logic [15:0] sp;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  opcode;
  logic [7:0]  imm;
  logic [7:0]  mem_data;
  logic [15:0] pc;
  logic        exec_en;
  logic        sp_dec;
  logic [4:0]  int_ack;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .imm_en(imm_en), .mem_op(mem_op), .is_halt(is_halt), .hl_addr(hl_addr),
    .reg_wdata(reg_wdata), .pc_load(pc_load), .pc_target(pc_target),
    .int_req(int_req), .ime(ime), .sp(sp), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .opcode(opcode),
    .imm(imm), .mem_data(mem_data), .pc(pc), .exec_en(exec_en),
    .sp_dec(sp_dec), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  // Toy instruction set decoded from the latched opcode:
  // bit1 = immediate, bits4:3 = mem_op, 0x76 = HALT, top 3 bits 111 = branch.
  logic [7:0] tgt_hi;
  assign imm_en    = opcode[1];
  assign mem_op    = opcode[4:3];
  assign is_halt   = (opcode == 8'h76);
  assign pc_load   = (opcode[7:5] == 3'b111);
  assign pc_target = {tgt_hi, imm};
  assign hl_addr   = {8'hC0, imm};
  assign reg_wdata = opcode ^ 8'h34;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 exec, 3 sp_dec, 4 ack
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  imm;
    logic [7:0]  md;
    int          cyc;
  } ev_t;

  ev_t obs[$];
  ev_t mon_e;
  ev_t last_ev;
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  ready_mode = 0;   // 0 always, 1 random, 2 two-cycle delay, 3 never
  int  wcnt = 0;
  logic rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus slave and event monitor; everything observed half a cycle after the edge.
  always @(negedge clk) begin
    case (ready_mode)
      0: rdy = 1'b1;
      1: rdy = ($urandom_range(0, 2) != 0);
      2: begin
        if (!(mem_rd || mem_wr)) begin
          rdy  = 1'b0;
          wcnt = 0;
        end else begin
          rdy  = (wcnt == 2);
          wcnt = rdy ? 0 : wcnt + 1;
        end
      end
      default: rdy = 1'b0;
    endcase
    mem_ready = rdy;
    mon_e = '{kind: 0, addr: 16'h0, data: 8'h0, imm: 8'h0, md: 8'h0, cyc: cyc};
    if (mem_rd || mem_wr) chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
    if ((mem_rd || mem_wr) && rdy) begin
      mon_e.kind = mem_wr ? 1 : 0;
      mon_e.addr = mem_addr;
      mon_e.data = mem_wr ? mem_wdata : mem_rdata;
      obs.push_back(mon_e);
      if (mem_wr) mem[mem_addr] = mem_wdata;
    end
    if (exec_en) begin
      mon_e = '{kind: 2, addr: pc, data: opcode, imm: imm, md: mem_data, cyc: cyc};
      obs.push_back(mon_e);
    end
    if (sp_dec) begin
      mon_e = '{kind: 3, addr: 16'h0, data: 8'h0, imm: 8'h0, md: 8'h0, cyc: cyc};
      obs.push_back(mon_e);
    end
    if (int_ack != 5'd0) begin
      mon_e = '{kind: 4, addr: 16'h0, data: {3'b000, int_ack}, imm: 8'h0, md: 8'h0, cyc: cyc};
      obs.push_back(mon_e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_ev(output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, addr: 16'h0, data: 8'h0, imm: 8'h0, md: 8'h0, cyc: 0};
    for (int i = 0; i < 300; i++) begin
      if (obs.size() > 0) begin
        e  = obs.pop_front();
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic exp_ev(input string tag, input int kind, input logic [15:0] addr,
                        input logic [7:0] data);
    ev_t e;
    bit  ok;
    get_ev(e, ok);
    chk({tag, "_arrived"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      chk({tag, "_kind"}, e.kind, kind);
      chk({tag, "_addr"}, {16'd0, e.addr}, {16'd0, addr});
      chk({tag, "_data"}, {24'd0, e.data}, {24'd0, data});
    end
    last_ev = e;
  endtask

  task automatic exp_exec(input string tag, input logic [15:0] epc, input logic [7:0] eop,
                          input logic [7:0] eimm, input logic [7:0] emd);
    exp_ev(tag, 2, epc, eop);
    if (last_ev.kind == 2) begin
      chk({tag, "_imm"}, {24'd0, last_ev.imm}, {24'd0, eimm});
      chk({tag, "_md"}, {24'd0, last_ev.md}, {24'd0, emd});
    end
  endtask

  task automatic rst_on();
    tick();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic rst_off();
    obs.delete();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
  endtask

  task automatic chk_reset(input string t);
    @(negedge clk);
    chk({t, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({t, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({t, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({t, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk({t, "_opcode"}, {24'd0, opcode}, 32'd0);
    chk({t, "_imm"}, {24'd0, imm}, 32'd0);
    chk({t, "_mem_data"}, {24'd0, mem_data}, 32'd0);
    chk({t, "_pc"}, {16'd0, pc}, 32'd0);
    chk({t, "_exec_en"}, {31'd0, exec_en}, 32'd0);
    chk({t, "_sp_dec"}, {31'd0, sp_dec}, 32'd0);
    chk({t, "_int_ack"}, {27'd0, int_ack}, 32'd0);
  endtask

  // Instruction-level reference: one call predicts every bus transfer and the
  // execute snapshot of the next instruction from the toy ISA rules.
  logic [15:0] m_pc;
  logic [7:0]  m_imm, m_md;

  task automatic run_instr(input int n);
    logic [7:0]  opc;
    logic [15:0] a;
    string       t;
    t   = $sformatf("rnd%0d", n);
    opc = ref_mem[m_pc];
    exp_ev({t, "_fetch"}, 0, m_pc, opc);
    m_pc = m_pc + 16'd1;
    if (opc[1]) begin
      m_imm = ref_mem[m_pc];
      exp_ev({t, "_imm"}, 0, m_pc, m_imm);
      m_pc = m_pc + 16'd1;
    end
    a = {8'hC0, m_imm};
    if (opc[4:3] == 2'b01) begin
      exp_ev({t, "_wr"}, 1, a, opc ^ 8'h34);
      ref_mem[a] = opc ^ 8'h34;
    end else if (opc[4:3] == 2'b10) begin
      m_md = ref_mem[a];
      exp_ev({t, "_rd"}, 0, a, m_md);
    end
    exp_exec({t, "_exec"}, m_pc, opc, m_imm, m_md);
    if (opc[7:5] == 3'b111) m_pc = {tgt_hi, m_imm};
  endtask

  int c0;

  initial begin
    rst     = 1'b1;
    ime     = 1'b0;
    int_req = 5'd0;
    sp      = 16'hFFFE;
    tgt_hi  = 8'h10;

    // Reset values, then NOP with zero-wait memory.
    clear_mem();
    rst_on();
    chk_reset("t1_rst");
    rst_off();
    exp_ev("t1_fetch0", 0, 16'h0000, 8'h00);
    c0 = last_ev.cyc;
    exp_exec("t1_exec", 16'h0001, 8'h00, 8'h00, 8'h00);
    chk("t1_exec_latency", last_ev.cyc - c0, 32'd2);
    exp_ev("t1_fetch1", 0, 16'h0001, 8'h00);

    // Immediate with two wait states per access.
    rst_on();
    clear_mem();
    mem[0] = 8'h06;
    mem[1] = 8'h5A;
    ready_mode = 2;
    rst_off();
    exp_ev("t2_fetch", 0, 16'h0000, 8'h06);
    exp_ev("t2_imm", 0, 16'h0001, 8'h5A);
    exp_exec("t2_exec", 16'h0002, 8'h06, 8'h5A, 8'h00);
    exp_ev("t2_next", 0, 16'h0002, 8'h00);

    // Data write phase.
    rst_on();
    clear_mem();
    mem[0] = 8'h08;
    rst_off();
    exp_ev("t3_fetch", 0, 16'h0000, 8'h08);
    exp_ev("t3_wr", 1, 16'hC000, 8'h3C);
    exp_exec("t3_exec", 16'h0001, 8'h08, 8'h00, 8'h00);
    exp_ev("t3_next", 0, 16'h0001, 8'h00);

    // HALT at 014F, wake into interrupt service.
    rst_on();
    clear_mem();
    ready_mode = 0;
    mem[16'h0000] = 8'hE2;
    mem[16'h0001] = 8'h4F;
    mem[16'h014F] = 8'h76;
    tgt_hi = 8'h01;
    ime    = 1'b1;
    sp     = 16'hFFFE;
    rst_off();
    exp_ev("t4_fetch", 0, 16'h0000, 8'hE2);
    exp_ev("t4_imm", 0, 16'h0001, 8'h4F);
    exp_exec("t4_exec", 16'h0002, 8'hE2, 8'h4F, 8'h00);
    exp_ev("t4_halt_fetch", 0, 16'h014F, 8'h76);
    repeat (6) tick();
    chk("t4_halt_quiet", obs.size(), 32'd0);
    int_req = 5'b00110;
    exp_ev("t4_push_hi", 1, 16'hFFFD, 8'h01);
    exp_ev("t4_spdec1", 3, 16'h0000, 8'h00);
    exp_ev("t4_push_lo", 1, 16'hFFFC, 8'h50);
    exp_ev("t4_spdec2", 3, 16'h0000, 8'h00);
    exp_ev("t4_ack", 4, 16'h0000, 8'h02);
    int_req = 5'd0;
    exp_ev("t4_vec_fetch", 0, 16'h0048, 8'h00);
    exp_exec("t4_vec_exec", 16'h0049, 8'h00, 8'h4F, 8'h00);

    // HALT with interrupts masked: wake without service.
    rst_on();
    clear_mem();
    mem[0] = 8'h76;
    ime    = 1'b0;
    rst_off();
    exp_ev("t5_halt_fetch", 0, 16'h0000, 8'h76);
    repeat (4) tick();
    chk("t5_halt_quiet", obs.size(), 32'd0);
    int_req = 5'b00001;
    exp_ev("t5_resume", 0, 16'h0001, 8'h00);
    int_req = 5'd0;
    exp_exec("t5_exec", 16'h0002, 8'h00, 8'h00, 8'h00);

    // PC wrap FFFF -> 0000.
    rst_on();
    clear_mem();
    mem[0] = 8'hE2;
    mem[1] = 8'hFF;
    tgt_hi = 8'hFF;
    rst_off();
    exp_ev("t6_fetch", 0, 16'h0000, 8'hE2);
    exp_ev("t6_imm", 0, 16'h0001, 8'hFF);
    exp_exec("t6_exec", 16'h0002, 8'hE2, 8'hFF, 8'h00);
    exp_ev("t6_fetch_ffff", 0, 16'hFFFF, 8'h00);
    exp_exec("t6_wrap_exec", 16'h0000, 8'h00, 8'hFF, 8'h00);
    exp_ev("t6_refetch", 0, 16'h0000, 8'hE2);

    // Reset while the immediate read is stalled.
    rst_on();
    clear_mem();
    mem[0] = 8'h06;
    ready_mode = 0;
    rst_off();
    exp_ev("t7_fetch", 0, 16'h0000, 8'h06);
    ready_mode = 3;
    tick();
    tick();
    @(negedge clk);
    chk("t7_imm_rd", {31'd0, mem_rd}, 32'd1);
    chk("t7_imm_addr", {16'd0, mem_addr}, 32'h0001);
    rst_on();
    chk_reset("t7_rst");
    chk("t7_no_xfer", obs.size(), 32'd0);
    ready_mode = 0;
    rst_off();
    exp_ev("t7_refetch", 0, 16'h0000, 8'h06);

    // Random programs with random wait states against the ISA-level model.
    rst_on();
    clear_mem();
    for (int i = 0; i < 16'h2000; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'h76) mem[i] = 8'h00;
    end
    for (int i = 16'hC000; i < 16'hC100; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    tgt_hi     = 8'h10;
    ime        = 1'($urandom);
    ready_mode = 1;
    m_pc  = 16'h0000;
    m_imm = 8'h00;
    m_md  = 8'h00;
    rst_off();
    for (int n = 0; n < 150; n++) run_instr(n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_rdata  in  8  bus read data, valid when mem_ready=1.
- mem_ready  in  1  bus transfer complete this cycle.
- imm_en  in  1  decoded: instruction has one immediate byte.
- mem_op  in  2  decoded: 00 none, 01 write, 10 read, 11 reserved (treated as none).
- is_halt  in  1  decoded: opcode is HALT.
- hl_addr  in  16  address for data memory phase.
- reg_wdata  in  8  store data for data write phase.
- pc_load  in  1  branch taken, sampled in EXEC.
- pc_target  in  16  branch target.
- int_req  in  5  pending interrupt flags (IE & IF), bit0 highest priority.
- ime  in  1  interrupt master enable.
- sp  in  16  current stack pointer.
- mem_addr  out  16  bus address.
- mem_wdata  out  8  bus write data.
- mem_rd  out  1  bus read request.
- mem_wr  out  1  bus write request.
- opcode  out  8  latched opcode, drives decoder.
- imm  out  8  latched immediate byte.
- mem_data  out  8  latched data-read byte.
- pc  out  16  program counter.
- exec_en  out  1  one-cycle execute strobe to datapath.
- sp_dec  out  1  one-cycle strobe: stack pointer decrements by 1.
- int_ack  out  5  one-hot acknowledge of serviced interrupt, one cycle.

Function
REQ-003 SHALL implement states FETCH, DECODE, IMM, MEM, EXEC, HALTED, PUSH_HI, PUSH_LO, VECTOR.
REQ-004 FETCH SHALL drive mem_rd=1, mem_addr=pc; on mem_ready latch opcode=mem_rdata, pc<=pc+1 (16-bit wrap FFFF->0000), go DECODE; otherwise hold all requests unchanged.
REQ-005 DECODE SHALL last exactly one cycle, no bus request; next: is_halt->HALTED, else imm_en->IMM, else mem_op 01/10->MEM, else EXEC.
REQ-006 IMM SHALL drive mem_rd=1, mem_addr=pc; on mem_ready latch imm, pc<=pc+1, go MEM if mem_op 01/10 else EXEC.
REQ-007 MEM SHALL drive mem_addr=hl_addr; mem_op 01: mem_wr=1, mem_wdata=reg_wdata; mem_op 10: mem_rd=1, latch mem_data on mem_ready; on mem_ready go EXEC.
REQ-008 mem_rd and mem_wr SHALL never be 1 in the same cycle; both 0 outside FETCH, IMM, MEM, PUSH_HI, PUSH_LO.
REQ-009 EXEC SHALL assert exec_en for exactly one cycle; if pc_load, pc<=pc_target; next: PUSH_HI if ime=1 and int_req!=0, else FETCH.
REQ-010 HALTED SHALL issue no bus requests; on int_req!=0 go PUSH_HI if ime=1, else FETCH (wake without service); int_req=0 holds.
REQ-011 PUSH_HI SHALL drive mem_wr=1, mem_addr=sp-1, mem_wdata=pc[15:8]; on mem_ready pulse sp_dec, go PUSH_LO.
REQ-012 PUSH_LO SHALL drive mem_wr=1, mem_addr=sp-2, mem_wdata=pc[7:0]; on mem_ready pulse sp_dec, go VECTOR (sp input not assumed updated before PUSH_LO).
REQ-013 VECTOR SHALL select lowest set bit n of int_req sampled this cycle, pulse int_ack bit n, pc<=16'h0040+8*n, go FETCH; if int_req=0 here, no ack, pc unchanged, go FETCH.
REQ-014 Latency with mem_ready=1 every cycle: plain op 3 cycles (FETCH, DECODE, EXEC); +1 per immediate, +1 per data phase; interrupt entry 3 cycles after EXEC/HALTED.
REQ-015 opcode, imm, mem_data SHALL hold until next latch event.

Reset
REQ-016 rst=1 at any clock edge, including mid-bus-transfer, SHALL force state FETCH, pc=RESET_PC, opcode=8'h00, imm=0, mem_data=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0, exec_en=0, sp_dec=0, int_ack=0 on the next cycle; abandoned transfer not completed.
REQ-017 First FETCH request SHALL appear in the first cycle after rst deasserts.

Verification
REQ-018 Reset release, mem_ready=1, memory 0000:00 -> mem_rd at 0000, exec_en in cycle 3, pc=0001, second fetch at 0001.
REQ-019 Opcode 06, imm 5A, mem_ready delayed 2 cycles per access -> imm=5A, pc advances by 2, exec_en once after imm latch.
REQ-020 mem_op=01, hl_addr=C000, reg_wdata=3C -> single write cycle C000<=3C, mem_rd=0 throughout MEM.
REQ-021 HALT, ime=1, sp=FFFE, pc=0150, int_req=5'b00110 -> writes FFFD<=01, FFFC<=50, two sp_dec pulses, int_ack=00010, pc=0048.
REQ-022 HALT, ime=0, int_req=00001 -> no push, no ack, fetch resumes at pc following HALT.
REQ-023 pc=FFFF fetch -> pc wraps to 0000; rst asserted during IMM wait -> next cycle all outputs at reset values, fetch at RESET_PC.
